// File: rtl/axi_lite_intr_slave.sv
`default_nettype none
// =============================================================================
// axi_lite_intr_slave : AXI4-Lite interrupt controller (GIER/IER/ISR/IAR/IPR).
// Define INTR_SYNC_EN to add a two-flop synchronizer on intr_in. Rev 1.0
// =============================================================================
module axi_lite_intr_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_OF_INTR      = 1,
  parameter int C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [C_NUM_OF_INTR-1:0]          intr_in,
  output logic                              irq
);

  localparam int C_DW      = C_S_AXI_DATA_WIDTH;
  localparam int C_WORD_AW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic C_IRQ_ON = (C_IRQ_ACTIVE_STATE != 0);
  localparam logic [C_DW-1:0] C_INTR_MASK = C_DW'((64'd1 << C_NUM_OF_INTR) - 64'd1);

  localparam logic [C_WORD_AW-1:0] C_OFF_GIER = C_WORD_AW'(0);
  localparam logic [C_WORD_AW-1:0] C_OFF_IER  = C_WORD_AW'(1);
  localparam logic [C_WORD_AW-1:0] C_OFF_ISR  = C_WORD_AW'(2);
  localparam logic [C_WORD_AW-1:0] C_OFF_IAR  = C_WORD_AW'(3);
  localparam logic [C_WORD_AW-1:0] C_OFF_IPR  = C_WORD_AW'(4);

  logic                     awready_q, awready_d;
  logic                     bvalid_q,  bvalid_d;
  logic                     arready_q, arready_d;
  logic                     rvalid_q,  rvalid_d;
  logic [C_DW-1:0]          rdata_q,   rdata_d;
  logic                     gier_q,    gier_d;
  logic [C_DW-1:0]          ier_q,     ier_d;
  logic [C_DW-1:0]          isr_q,     isr_d;
  logic [C_NUM_OF_INTR-1:0] intr_low_q, intr_low_d;
  logic                     irq_q,     irq_d;

  logic                     w_wr_en;
  logic                     w_rd_en;
  logic [C_WORD_AW-1:0]     w_aw_word;
  logic [C_WORD_AW-1:0]     w_ar_word;
  logic [C_DW-1:0]          w_wmask;
  logic [C_DW-1:0]          w_iar_clr;
  logic [C_DW-1:0]          w_rd_val;
  logic [C_DW-1:0]          w_rise;
  logic [C_NUM_OF_INTR-1:0] w_intr_smp;

  assign w_wr_en   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_en   = arready_q & S_AXI_ARVALID;
  assign w_aw_word = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ar_word = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  genvar lane;
  generate
    for (lane = 0; lane < C_DW/8; lane++) begin : g_lane
      assign w_wmask[lane*8 +: 8] = {8{S_AXI_WSTRB[lane]}};
    end
  endgenerate

`ifdef INTR_SYNC_EN
  logic [C_NUM_OF_INTR-1:0] sync1_q, sync1_d;
  logic [C_NUM_OF_INTR-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = intr_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign w_intr_smp = sync2_q;
`else
  assign w_intr_smp = intr_in;
`endif

  // History holds "was low last sample", so a level already high out of reset never counts as an edge.
  assign w_rise = C_DW'(w_intr_smp & intr_low_q);

  always_comb begin
    w_rd_val = '0;
    case (w_ar_word)
      C_OFF_GIER: w_rd_val = C_DW'(gier_q);
      C_OFF_IER:  w_rd_val = ier_q;
      C_OFF_ISR:  w_rd_val = isr_q;
      C_OFF_IPR:  w_rd_val = isr_q & ier_q;
      default:    w_rd_val = '0;
    endcase
  end

  always_comb begin
    awready_d  = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
    arready_d  = S_AXI_ARVALID & ~arready_q & ~rvalid_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    gier_d     = gier_q;
    ier_d      = ier_q;
    w_iar_clr  = '0;
    intr_low_d = ~w_intr_smp;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (w_wr_en)                  bvalid_d = 1'b1;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (w_rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = w_rd_val;
    end

    if (w_wr_en) begin
      case (w_aw_word)
        C_OFF_GIER: if (S_AXI_WSTRB[0]) gier_d = S_AXI_WDATA[0];
        C_OFF_IER:  ier_d = ((ier_q & ~w_wmask) | (S_AXI_WDATA & w_wmask)) & C_INTR_MASK;
        C_OFF_IAR:  w_iar_clr = S_AXI_WDATA & w_wmask;
        default:    ;
      endcase
    end

    // A fresh edge overrides a same-cycle acknowledge.
    isr_d = ((isr_q & ~w_iar_clr) | w_rise) & C_INTR_MASK;
    irq_d = (gier_q && |(isr_q & ier_q)) ? C_IRQ_ON : ~C_IRQ_ON;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      gier_q     <= 1'b0;
      ier_q      <= '0;
      isr_q      <= '0;
      intr_low_q <= '0;
      irq_q      <= ~C_IRQ_ON;
    end else begin
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      gier_q     <= gier_d;
      ier_q      <= ier_d;
      isr_q      <= isr_d;
      intr_low_q <= intr_low_d;
      irq_q      <= irq_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_intr_slave.sv
`default_nettype none
// tb_axi_lite_intr_slave : directed + randomized bench against a transaction-level model
// of the interrupt controller (4 sources, active-high irq).
module tb_axi_lite_intr_slave;
  localparam int NI = 4;
  localparam logic [31:0] MASK = 32'h0000_000F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]    AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]   WDATA, RDATA;
  logic [3:0]    WSTRB;
  logic [1:0]    BRESP, RRESP;
  logic [NI-1:0] intr_in;
  logic          irq;

  axi_lite_intr_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
    .C_NUM_OF_INTR(NI), .C_IRQ_ACTIVE_STATE(1)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .intr_in(intr_in), .irq(irq)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: register file updated at transaction granularity.
  logic          m_gier;
  logic [31:0]   m_ier, m_isr, m_rexp;
  logic [NI-1:0] m_prev;
  logic          m_irq;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0:    return {31'd0, m_gier};
      3'd1:    return m_ier;
      3'd2:    return m_isr;
      3'd4:    return m_isr & m_ier;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ack_bits();
    if (AWREADY && AWVALID && WVALID && AWADDR[4:2] == 3'd3) return merge(32'd0, WDATA, WSTRB);
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gier <= 1'b0;
      m_ier  <= 32'd0;
      m_isr  <= 32'd0;
      m_prev <= '1;
      m_irq  <= 1'b0;
      m_rexp <= 32'd0;
    end else begin
      if (AWREADY && AWVALID && WVALID) begin
        if (AWADDR[4:2] == 3'd0 && WSTRB[0]) m_gier <= WDATA[0];
        if (AWADDR[4:2] == 3'd1) m_ier <= merge(m_ier, WDATA, WSTRB) & MASK;
      end
      m_isr  <= ((m_isr & ~ack_bits()) | 32'(intr_in & ~m_prev)) & MASK;
      m_prev <= intr_in;
      m_irq  <= m_gier & (|(m_isr & m_ier));
      if (ARREADY && ARVALID) m_rexp <= model_read(ARADDR);
    end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit kick = 1'b0);
    @(negedge clk);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (AWREADY) break;
    end
    check("awready", 32'(AWREADY), 32'd1);
    check("wready", 32'(WREADY), 32'd1);
    if (kick) intr_in[0] = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("bvalid", 32'(BVALID), 32'd1);
    check("bresp", 32'(BRESP), 32'd0);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    ARADDR = a; ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ARREADY) break;
    end
    check("arready", 32'(ARREADY), 32'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    check("rvalid", 32'(RVALID), 32'd1);
    check("rresp", 32'(RRESP), 32'd0);
    check("rdata", RDATA, m_rexp);
    d = RDATA;
  endtask

  task automatic pulse0();
    @(negedge clk); intr_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); intr_in[0] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        seen;
    logic [4:0]  rst_addrs[4];
    logic [4:0]  waddrs[6];
    logic [4:0]  raddrs[8];
    rst_addrs = '{5'h00, 5'h04, 5'h08, 5'h10};
    waddrs    = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h18};
    raddrs    = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};

    AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0; WDATA = '0; WSTRB = '0;
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1; intr_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_irq", 32'(irq), 32'd0);
    check("rst_handshake", 32'({AWREADY, WREADY, BVALID, ARREADY, RVALID}), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(rst_addrs[i], d);
      check("rst_reg", d, 32'd0);
    end

    // Enabled interrupt raises irq; acknowledge drops it.
    axi_write(5'h00, 32'd1, 4'hF);
    axi_write(5'h04, 32'd1, 4'hF);
    pulse0();
    check("irq_on", 32'(irq), 32'd1);
    axi_read(5'h08, d); check("isr_set", d, 32'd1);
    axi_read(5'h10, d); check("ipr_set", d, 32'd1);
    axi_write(5'h0C, 32'd1, 4'hF);
    repeat (2) @(negedge clk);
    check("irq_off_after_ack", 32'(irq), 32'd0);
    axi_read(5'h10, d); check("ipr_cleared", d, 32'd0);

    // Masked source latches in ISR but not IPR.
    axi_write(5'h04, 32'd0, 4'hF);
    pulse0();
    repeat (2) @(negedge clk);
    check("irq_masked", 32'(irq), 32'd0);
    axi_read(5'h08, d); check("isr_masked", d, 32'd1);
    axi_read(5'h10, d); check("ipr_masked", d, 32'd0);
    axi_write(5'h04, 32'd1, 4'hF);
    repeat (2) @(negedge clk);
    check("irq_after_enable", 32'(irq), 32'd1);

    // Acknowledge colliding with a new edge.
    axi_write(5'h0C, 32'd1, 4'hF, 1'b1);
    @(negedge clk); intr_in[0] = 1'b0;
    axi_read(5'h08, d); check("isr_edge_wins", d, 32'd1);

    // Read of ISR concurrent with an acknowledge returns the pre-write value.
    fork
      axi_write(5'h0C, 32'd1, 4'hF);
      axi_read(5'h08, d);
    join
    check("isr_read_pre_ack", d, 32'd1);
    axi_read(5'h08, d); check("isr_after_ack", d, 32'd0);

    // Response hold with BREADY low, valids kept high.
    BREADY = 1'b0;
    @(negedge clk);
    AWADDR = 5'h04; WDATA = 32'd1; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (AWREADY) break;
    end
    check("hold_awready", 32'(AWREADY), 32'd1);
    @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(BVALID), 32'd1);
      seen = seen | AWREADY;
    end
    check("no_second_awready", 32'(seen), 32'd0);
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    @(negedge clk);
    check("bvalid_released", 32'(BVALID), 32'd0);

    RREADY = 1'b0;
    @(negedge clk);
    ARADDR = 5'h04; ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ARREADY) break;
    end
    check("hold_arready", 32'(ARREADY), 32'd1);
    @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rvalid_hold", 32'(RVALID), 32'd1);
      check("rdata_hold", RDATA, 32'd1);
      seen = seen | ARREADY;
    end
    check("no_second_arready", 32'(seen), 32'd0);
    ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge clk);
    check("rvalid_released", 32'(RVALID), 32'd0);

    // Byte strobes, width masking and unmapped space.
    axi_write(5'h04, 32'hFFFF_FFFF, 4'b0001);
    axi_read(5'h04, d); check("ier_strb_mask", d, 32'h0000_000F);
    axi_write(5'h04, 32'h0000_0000, 4'b1110);
    axi_read(5'h04, d); check("ier_strb_keep", d, 32'h0000_000F);
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h18, d); check("unmapped_read", d, 32'd0);

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0: axi_write(waddrs[$urandom_range(0, 5)], $urandom, 4'($urandom));
        1: axi_read(raddrs[$urandom_range(0, 7)], d);
        default: begin
          @(negedge clk);
          intr_in = NI'($urandom);
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      endcase
      check("irq_rand", 32'(irq), 32'(m_irq));
    end

    // Reset during a pending response aborts it; sources held high must not latch.
    BREADY = 1'b0;
    intr_in = '1;
    @(negedge clk);
    AWADDR = 5'h00; WDATA = 32'd1; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (AWREADY) break;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bvalid", 32'(BVALID), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | BVALID;
    end
    check("no_resp_after_rst", 32'(seen), 32'd0);
    BREADY = 1'b1;
    axi_read(5'h00, d); check("gier_after_rst", d, 32'd0);
    axi_read(5'h08, d); check("isr_held_high", d, 32'd0);
    @(negedge clk); intr_in = '0;
    @(negedge clk); intr_in = '1;
    axi_read(5'h08, d); check("isr_after_low", d, 32'h0000_000F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_lite_intr_slave.md
AXI_LITE_INTR_SLAVE -- requirements
Module: axi_lite_intr_slave

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI-Lite data width (fixed 32).
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width.
REQ-003 The block SHALL have parameter C_NUM_OF_INTR, default 1, number of interrupt sources (1..32).
REQ-004 The block SHALL have parameter C_IRQ_ACTIVE_STATE, default 1, irq output polarity.
REQ-005 The block SHALL have port S_AXI_ACLK, input, 1 bit: the single clock.
REQ-006 The block SHALL have port S_AXI_ARESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have ports S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, in/in/in/out, ADDR/3/1/1 bits: write address channel.
REQ-008 The block SHALL have ports S_AXI_WDATA/WSTRB/WVALID/WREADY, in/in/in/out, 32/4/1/1 bits: write data channel.
REQ-009 The block SHALL have ports S_AXI_BRESP/BVALID/BREADY, out/out/in, 2/1/1 bits: write response channel.
REQ-010 The block SHALL have ports S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, in/in/in/out, ADDR/3/1/1 bits: read address channel.
REQ-011 The block SHALL have ports S_AXI_RDATA/RRESP/RVALID/RREADY, out/out/out/in, 32/2/1/1 bits: read data channel.
REQ-012 The block SHALL have port intr_in, input, C_NUM_OF_INTR bits: interrupt sources, rising-edge sensitive.
REQ-013 The block SHALL have port irq, output, 1 bit: combined interrupt request, C_IRQ_ACTIVE_STATE polarity.

Function
REQ-014 Register map (byte offset, word-aligned; ADDR[1:0] ignored): 0x00 GIER bit0 RW, 0x04 IER RW, 0x08 ISR RO, 0x0C IAR W1C (reads 0), 0x10 IPR RO = ISR & IER.
REQ-015 Write handshake: AWREADY and WREADY SHALL both pulse high for exactly one cycle, only when AWVALID and WVALID are both high and BVALID is low; register update occurs on that edge.
REQ-016 BVALID SHALL rise the cycle after the AW/W acceptance and hold until BREADY is sampled high; BRESP SHALL always be 2'b00.
REQ-017 Read handshake: ARREADY SHALL pulse one cycle when ARVALID is high and RVALID is low; RVALID and RDATA SHALL follow next cycle and hold stable until RREADY is sampled high; RRESP SHALL be 2'b00.
REQ-018 Accesses to unmapped offsets (0x14-0x1C) SHALL complete with OKAY; reads return 0; writes have no effect.
REQ-019 Writes SHALL honour WSTRB per byte lane; bits at or above C_NUM_OF_INTR in IER, ISR, and IPR SHALL read 0.
REQ-020 ISR[i] SHALL set on the cycle after intr_in[i] is seen 0 then 1 on consecutive edges, independent of IER and GIER.
REQ-021 Writing 1 to IAR[i] SHALL clear ISR[i]; a new rising edge in the same cycle SHALL win, leaving ISR[i]=1.
REQ-022 irq SHALL be registered: active one cycle after (GIER[0] & |IPR) becomes 1; inactive one cycle after it becomes 0.
REQ-023 Read and write channels SHALL operate independently; a read of ISR/IPR in the same cycle as an IAR write SHALL return the pre-write value.

Reset
REQ-024 On S_AXI_ARESETN low, asynchronously: GIER, IER, ISR = 0; edge-detect history = 0; all READY/VALID outputs = 0; RDATA = 0; irq = inactive (~C_IRQ_ACTIVE_STATE).
REQ-025 Reset asserted mid-transaction SHALL abort it silently; no response SHALL be issued after release.
REQ-026 After release, intr_in held high SHALL NOT set ISR until it has been low for at least one sample.

Configuration
REQ-027 With INTR_SYNC_EN defined, intr_in SHALL pass through a two-flop synchronizer before edge detection (ISR set latency 3 cycles from input edge); without it, intr_in SHALL be sampled directly (latency 1 cycle, REQ-020).

Verification
REQ-028 Reset, read 0x00/0x04/0x08/0x10 -> all 0x00000000, irq inactive, BRESP/RRESP 0.
REQ-029 Write GIER=1, IER=1, pulse intr_in[0] -> ISR=1, IPR=1, irq active; write IAR=1 -> IPR reads 0, irq inactive within 2 cycles.
REQ-030 IER=0, GIER=1, intr_in[0] edge -> ISR=1, IPR=0, irq stays inactive; then IER=1 -> irq active.
REQ-031 IAR=1 write coinciding with a new intr_in[0] edge -> ISR remains 1.
REQ-032 Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and RDATA stable, no second AWREADY/ARREADY pulse.
REQ-033 Write 0xFFFFFFFF to IER with WSTRB=4'b0001, C_NUM_OF_INTR=4 -> IER reads 0x0000000F; write to 0x18 -> OKAY, reads 0.
